serial_frame_deser: RTL and testbench
=====================================

# serial_frame_deser

Serial-to-parallel receive stage that sits directly downstream of the serial delay line (`eq_n`). It consumes that line's 1-bit output stream, hunts for a sync pattern, then assembles a fixed number of MSB-first words per frame. Each word is presented on a valid/ready output with a single-entry holding register. Words that cannot be accepted are dropped and flagged.

## Interface
- `WIDTH`, 8: data word width in bits (≥2).
- `SYNC_W`, 8: sync pattern width in bits (≥2).
- `SYNC_PAT`, 8'hA5: sync pattern, MSB received first.
- `FRAME_WORDS`, 4: data words per frame after sync (≥1).

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset; asynchronous assert, active-low.
- `din` input 1: serial data bit; connects to the delay line's `q`.
- `din_en` input 1: `din` is sampled only in cycles where `din_en`=1.
- `out_data` output WIDTH: assembled word, first-received bit in the MSB.
- `out_valid` output 1: `out_data`/`out_last` hold a word.
- `out_ready` input 1: consumer accepts the word when `out_valid`&`out_ready`.
- `out_last` output 1: word is the final word of its frame.
- `locked` output 1: the FSM is in DATA.
- `overflow` output 1: one-cycle pulse when a completed word is dropped.

## Operation
- Two-state FSM: HUNT, DATA.
- **HUNT**
  - On each `din_en`, the SYNC_W-bit history register shifts left with `din` entering the LSB.
  - Match condition: `{hist[SYNC_W-2:0], din} == SYNC_PAT` with `din_en`=1.
  - On a match, go to DATA with bit_cnt=0 and word_cnt=0.
- **DATA**
  - On each `din_en`, shift `din` into the assembly register and increment bit_cnt.
  - The history register does not update in DATA.
  - When the WIDTH-th bit is sampled, the word completes: bit_cnt wraps to 0 and word_cnt increments.
  - On the completion of word FRAME_WORDS, return to HUNT and clear the history register to 0. Bits from the previous frame therefore never contribute to the next sync match.
- **Output register**
  - Single-entry register holding `out_data`, `out_valid` and `out_last`.
  - A completed word loads when the register is empty, or when it is being consumed in the same cycle (`out_valid`&`out_ready`).
  - Otherwise the completed word is discarded, `overflow` pulses for that cycle, and the held word is unchanged.
  - Frame and word counting continue regardless of drops.
  - `out_last` = 1 for word index FRAME_WORDS-1.
  - `out_valid` falls after a handshake unless a new word loads in the same cycle.
- `din` is ignored when `din_en`=0; idle gaps of any length between bits are legal.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `out_last`=0, `locked`=0, `overflow`=0; FSM=HUNT; all counters and history=0.
- **Latency:** the last bit of a word is sampled at edge N; `out_valid`=1 with that word after edge N.
- **Lock timing:** `locked` rises after the edge that samples the final sync bit. It falls after the edge that samples the final bit of the last word, i.e. in the same cycle `out_valid` rises for that word.
- **`overflow` timing:** registered; high for the one cycle after the edge at which the drop is decided.
- **Reset mid-frame:** a partial word is discarded, any held output word is lost, and the FSM returns to HUNT immediately.
- `out_data` stays stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package: FSM state enum (HUNT, DATA).
- Counter widths derive locally: `$clog2(WIDTH)` for bit_cnt, `$clog2(FRAME_WORDS)` for word_cnt, with a minimum of 1 bit each.
- One natural sub-module: `out_hold_reg`, the single-entry valid/ready holding register with drop detect.
- Sync matching, assembly and the FSM stay in the top module.

## Test plan
All scenarios use WIDTH=8, SYNC_PAT=8'hA5, FRAME_WORDS=2 unless stated, with the history register empty at start.
- **Reset:** hold `rst_n`=0 with `din` toggling → all outputs 0. Release, then feed 16 zero bits → `locked` stays 0 and no `out_valid`.
- **Basic frame:** bits A5, 3C, C3 with `din_en`=1 every cycle and `out_ready`=1 → words 3C (`out_last`=0) then C3 (`out_last`=1), each valid for one cycle. `locked` is high for exactly 16 cycles.
- **Sync near-miss:** bits A4 then A5 → no lock on A4. Lock occurs only on the final bit of A5.
- **Bit gaps:** `din_en` asserted every third cycle for the basic frame → identical words; `out_valid` one cycle after each final bit.
- **Backpressure:** `out_ready`=0, then frame A5, 11, 22 → 11 is held and 22 is dropped. `overflow` pulses exactly once. Raising `out_ready` then returns 11 with `out_last`=0.
- **Reset mid-frame:** assert `rst_n` after A5 plus 4 data bits → `locked`=0 immediately and no output. A subsequent full frame A5, 5A, 69 yields 5A, 69.

Source files
------------

// File: rtl/serial_frame_deser_pkg.sv
// Shared types for the serial frame deserializer.
package serial_frame_deser_pkg;
  typedef enum logic {HUNT = 1'b0, DATA = 1'b1} fsm_state_t;
endpackage

// File: rtl/serial_frame_deser_out_hold.sv
// Single-entry valid/ready holding register; completed words arriving while
// the entry is occupied and not draining are dropped and flagged.
module out_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              overflow
);
  logic drain;
  logic accept;

  assign drain  = out_valid && out_ready;
  assign accept = load && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= load && !accept;
      if (accept) begin
        out_data  <= load_data;
        out_last  <= load_last;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/serial_frame_deser.sv
// Serial receive stage: hunts for a sync pattern, then assembles FRAME_WORDS
// MSB-first words per frame into a valid/ready holding register.
module serial_frame_deser
  import serial_frame_deser_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter int                SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT    = 8'hA5,
  parameter int                FRAME_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             locked,
  output logic             overflow
);
  localparam int BC_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int WC_W = ($clog2(FRAME_WORDS) > 0) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WIDTH - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(FRAME_WORDS - 1);

  fsm_state_t        state;
  // Only the newest SYNC_W-1 history bits are ever compared, so the oldest is not stored.
  logic [SYNC_W-2:0] hist;
  logic [WIDTH-2:0]  shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [SYNC_W-1:0] sync_win;
  logic [WIDTH-1:0]  word_val;
  logic              word_done;
  logic              word_last;

  assign sync_win  = {hist, din};
  assign word_val  = {shreg, din};
  assign word_last = (word_cnt == WORD_LAST);
  assign word_done = din_en && (state == DATA) && (bit_cnt == BIT_LAST);
  assign locked    = (state == DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      hist     <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (din_en) begin
      case (state)
        HUNT: begin
          hist <= sync_win[SYNC_W-2:0];
          if (sync_win == SYNC_PAT) begin
            state    <= DATA;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (word_last) begin
              // Clearing history keeps stale frame bits out of the next sync match.
              state    <= HUNT;
              word_cnt <= '0;
              hist     <= '0;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (din_en && (state == DATA)) shreg <= word_val[WIDTH-2:0];
  end

  out_hold_reg #(.DATA_W(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (word_done),
    .load_data (word_val),
    .load_last (word_last),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .overflow  (overflow)
  );
endmodule

// File: tb/tb_serial_frame_deser.sv
// Bench for serial_frame_deser: vector table of frames plus hand-written
// reset, backpressure and mid-frame reset sequences, with a word scoreboard.
module tb_serial_frame_deser;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       locked;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int lock_cycles = 0;
  int valid_cycles = 0;
  int ovf_cnt = 0;

  typedef struct {
    logic [7:0] pre;
    logic [7:0] sync;
    logic [7:0] d0;
    logic [7:0] d1;
    int         gap;
    bit         exp_lock;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  vec_t vecs[5];
  exp_t sbq[$];
  exp_t pe;

  serial_frame_deser #(
    .WIDTH(8), .SYNC_W(8), .SYNC_PAT(8'hA5), .FRAME_WORDS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_en    (din_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .locked    (locked),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: sample just after the falling edge, i.e. the values the next rising edge uses.
  always begin
    @(negedge clk);
    #1;
    if (rst_n === 1'b1) begin
      if (locked) lock_cycles++;
      if (out_valid) valid_cycles++;
      if (overflow) ovf_cnt++;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got=%0h exp=none", out_data);
        end else begin
          pe = sbq.pop_front();
          check("word_data", {24'd0, out_data}, {24'd0, pe.data});
          check("word_last", {31'd0, out_last}, {31'd0, pe.last});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Entered and left on a falling edge; the bit is sampled by the rising edge between.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      din_en = 1'b0;
      din = 1'($urandom);
      @(negedge clk);
    end
    din = b;
    din_en = 1'b1;
    @(negedge clk);
    din_en = 1'b0;
  endtask

  task automatic idle(input int n);
    din_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] e, input logic last, input int gap);
    sbq.push_back('{data: e, last: last});
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
    check("valid_latency", {31'd0, out_valid}, 32'd1);
    if (last) check("unlock_on_last", {31'd0, locked}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] pre, input logic [7:0] sync, input logic [7:0] d0,
                           input logic [7:0] d1, input int gap, input bit exp_lock,
                           input logic [7:0] e0, input logic [7:0] e1);
    lock_cycles = 0;
    for (int i = 7; i >= 0; i--) send_bit(pre[i], gap);
    check("pre_nolock", {31'd0, locked}, 32'd0);
    for (int i = 7; i >= 1; i--) send_bit(sync[i], gap);
    check("sync_early_nolock", {31'd0, locked}, 32'd0);
    send_bit(sync[0], gap);
    check("sync_lock", {31'd0, locked}, {31'd0, exp_lock});
    if (exp_lock) begin
      send_word(d0, e0, 1'b0, gap);
      send_word(d1, e1, 1'b1, gap);
      check("lock_cycles", lock_cycles, 32'(16 * (gap + 1)));
    end
    idle(3);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'hA5, 8'h3C, 8'hC3, 0, 1'b1, 8'h3C, 8'hC3};
    vecs[1] = '{8'hA4, 8'hA5, 8'h5A, 8'h69, 0, 1'b1, 8'h5A, 8'h69};
    vecs[2] = '{8'h00, 8'hA5, 8'h3C, 8'hC3, 2, 1'b1, 8'h3C, 8'hC3};
    vecs[3] = '{8'hFF, 8'hA4, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{8'h00, 8'hA5, 8'hFF, 8'h00, 1, 1'b1, 8'hFF, 8'h00};

    rst_n = 1'b0;
    din = 1'b0;
    din_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din = ~din;
    end
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    din_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    lock_cycles = 0;
    valid_cycles = 0;
    for (int i = 0; i < 16; i++) send_bit(1'b0, 0);
    idle(2);
    check("zeros_no_lock", lock_cycles, 32'd0);
    check("zeros_no_valid", valid_cycles, 32'd0);

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].pre, vecs[v].sync, vecs[v].d0, vecs[v].d1, vecs[v].gap,
                vecs[v].exp_lock, vecs[v].exp0, vecs[v].exp1);
    check("table_queue_empty", sbq.size(), 32'd0);

    // Backpressure: first word held, second word dropped.
    out_ready = 1'b0;
    ovf_cnt = 0;
    for (int i = 7; i >= 0; i--) send_bit(8'hA5 >> i, 0);
    check("bp_lock", {31'd0, locked}, 32'd1);
    for (int i = 7; i >= 0; i--) send_bit(8'h11 >> i, 0);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 7; i >= 0; i--) send_bit(8'h22 >> i, 0);
    check("bp_overflow", {31'd0, overflow}, 32'd1);
    check("bp_held_data", {24'd0, out_data}, 32'h11);
    check("bp_held_last", {31'd0, out_last}, 32'd0);
    idle(3);
    check("bp_overflow_once", ovf_cnt, 32'd1);
    check("bp_still_held", {24'd0, out_data}, 32'h11);
    sbq.push_back('{data: 8'h11, last: 1'b0});
    out_ready = 1'b1;
    idle(1);
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    idle(2);
    check("bp_queue_empty", sbq.size(), 32'd0);

    // Reset in the middle of the first data word.
    for (int i = 7; i >= 0; i--) send_bit(8'hA5 >> i, 0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0);
    check("mid_locked_before", {31'd0, locked}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    valid_cycles = 0;
    idle(2);
    check("mid_no_output", valid_cycles, 32'd0);
    run_frame(8'h00, 8'hA5, 8'h5A, 8'h69, 0, 1'b1, 8'h5A, 8'h69);
    check("final_queue_empty", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
